// File: rtl/i2c_responder.sv
// I2C target: START/STOP decode, 7-bit address match, pointer/data writes as
// single-cycle register strobes, and reads with pointer auto-increment.
module i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       osc_50,
  input  logic       reset_50m_n,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       addressed
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {S_IDLE, S_DEV, S_PTR, S_WR, S_RD, S_MACK} state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              ack_ph, ack_ph_n;
  logic              full, full_n;
  logic [BYTE_W-1:0] shreg, shreg_n;
  logic              sda_drive_low, sda_drive_low_n;
  logic [BYTE_W-1:0] reg_addr_n, reg_wdata_n;
  logic              reg_wr_en_n, addressed_n;

  assign I2C_SDAT = sda_drive_low ? 1'b0 : 1'bz;

  // Two-flop synchronisers plus one history flop per line
  always_ff @(posedge osc_50 or negedge reset_50m_n) begin
    if (!reset_50m_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= I2C_SCLK; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= I2C_SDAT; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  always_ff @(posedge osc_50 or negedge reset_50m_n) begin
    if (!reset_50m_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      ack_ph        <= 1'b0;
      full          <= 1'b0;
      shreg         <= '0;
      sda_drive_low <= 1'b0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wr_en     <= 1'b0;
      addressed     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ack_ph        <= ack_ph_n;
      full          <= full_n;
      shreg         <= shreg_n;
      sda_drive_low <= sda_drive_low_n;
      reg_addr      <= reg_addr_n;
      reg_wdata     <= reg_wdata_n;
      reg_wr_en     <= reg_wr_en_n;
      addressed     <= addressed_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    ack_ph_n        = ack_ph;
    full_n          = full;
    shreg_n         = shreg;
    sda_drive_low_n = sda_drive_low;
    reg_addr_n      = reg_wr_en ? reg_addr + 8'd1 : reg_addr;
    reg_wdata_n     = reg_wdata;
    reg_wr_en_n     = 1'b0;
    addressed_n     = addressed;

    if (start_det || stop_det) begin
      // Bus conditions abort any byte in flight
      state_n         = start_det ? S_DEV : S_IDLE;
      cnt_n           = '0;
      ack_ph_n        = 1'b0;
      full_n          = 1'b0;
      sda_drive_low_n = 1'b0;
      addressed_n     = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_DEV, S_PTR, S_WR: begin
          if (scl_rise && !ack_ph) begin
            shreg_n = {shreg[6:0], sda_s2};
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) full_n = 1'b1;
          end else if (scl_fall && full) begin
            full_n          = 1'b0;
            ack_ph_n        = 1'b1;
            sda_drive_low_n = 1'b1;
            if (state == S_DEV) begin
              if (shreg[7:1] == DEV_ADDR) begin
                addressed_n = 1'b1;
                state_n     = shreg[0] ? S_RD : S_PTR;
              end else begin
                ack_ph_n        = 1'b0;
                sda_drive_low_n = 1'b0;
                state_n         = S_IDLE;
              end
            end else if (state == S_PTR) begin
              reg_addr_n = shreg;
              state_n    = S_WR;
            end else begin
              reg_wdata_n = shreg;
              reg_wr_en_n = 1'b1;
            end
          end else if (scl_fall && ack_ph) begin
            ack_ph_n        = 1'b0;
            sda_drive_low_n = 1'b0;
          end
        end
        S_RD: begin
          // Load on the fall ending the ACK; cnt wraps to 0 after the 8th bit
          if (scl_fall) begin
            if (ack_ph) begin
              shreg_n         = reg_rdata;
              sda_drive_low_n = ~reg_rdata[7];
              cnt_n           = 3'd1;
              ack_ph_n        = 1'b0;
            end else if (cnt == 3'd0) begin
              sda_drive_low_n = 1'b0;
              state_n         = S_MACK;
            end else begin
              shreg_n         = {shreg[6:0], 1'b0};
              sda_drive_low_n = ~shreg[6];
              cnt_n           = cnt + 3'd1;
            end
          end
        end
        S_MACK: begin
          if (scl_rise) begin
            if (!sda_s2) begin
              reg_addr_n = reg_addr + 8'd1;
              ack_ph_n   = 1'b1;
              state_n    = S_RD;
            end else begin
              addressed_n = 1'b0;
              state_n     = S_IDLE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule
